// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Byte-stream boot loader. Assembles little-endian words, writes
//             them to instruction memory, verifies an XOR checksum and holds
//             the CPU core in reset until a load completes successfully.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        load_req,
    output logic [31:0] tb_addr,
    output logic [31:0] tb_inst,
    output logic        tb_we,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        err
);

    localparam int          c_idx_w     = $clog2(IMEM_WORDS) + 1;
    localparam logic [31:0] c_max_words = 32'(IMEM_WORDS);

    localparam logic [2:0] c_st_hdr   = 3'd0;
    localparam logic [2:0] c_st_data  = 3'd1;
    localparam logic [2:0] c_st_write = 3'd2;
    localparam logic [2:0] c_st_csum  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
    localparam logic [2:0] c_st_err   = 3'd5;

    logic [2:0]         r_state;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_word_buf;
    logic [31:0]        r_count;
    logic [c_idx_w-1:0] r_index;
    logic [31:0]        r_csum;

    logic [31:0]        w_word;
    logic               w_fire;
    logic               w_last_byte;
    logic [c_idx_w-1:0] w_index_next;
    logic [31:0]        w_index_ext;
    logic [31:0]        w_addr;

    // in_ready is gated by reset_n so no byte is offered as accepted while held in reset
    assign in_ready = reset_n &&
                      ((r_state == c_st_hdr) || (r_state == c_st_data) || (r_state == c_st_csum));

    assign w_fire       = in_valid && in_ready;
    assign w_last_byte  = w_fire && (r_byte_cnt == 2'd3);
    assign w_index_next = r_index + {{(c_idx_w-1){1'b0}}, 1'b1};
    assign w_index_ext  = {{(32-c_idx_w){1'b0}}, w_index_next};
    assign w_addr       = BASE_ADDR + {{(30-c_idx_w){1'b0}}, r_index, 2'b00};

    always_comb begin
        w_word = r_word_buf;
        w_word[{r_byte_cnt, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_hdr;
            r_byte_cnt  <= 2'd0;
            r_word_buf  <= 32'd0;
            r_count     <= 32'd0;
            r_index     <= '0;
            r_csum      <= 32'd0;
            tb_addr     <= BASE_ADDR;
            tb_inst     <= 32'd0;
            tb_we       <= 1'b0;
            cpu_reset_n <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            tb_we <= 1'b0;
            if (w_fire) begin
                r_word_buf <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            case (r_state)
                c_st_hdr: begin
                    if (w_last_byte) begin
                        r_count <= w_word;
                        if (w_word > c_max_words) begin
                            r_state <= c_st_err;
                            err     <= 1'b1;
                        end else if (w_word == 32'd0) begin
                            r_state <= c_st_csum;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (w_last_byte) r_state <= c_st_write;
                end
                c_st_write: begin
                    tb_we   <= 1'b1;
                    tb_addr <= w_addr;
                    tb_inst <= r_word_buf;
                    r_csum  <= r_csum ^ r_word_buf;
                    r_index <= w_index_next;
                    r_state <= (w_index_ext == r_count) ? c_st_csum : c_st_data;
                end
                c_st_csum: begin
                    if (w_last_byte) begin
                        if (w_word == r_csum) begin
                            r_state     <= c_st_done;
                            done        <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            r_state <= c_st_err;
                            err     <= 1'b1;
                        end
                    end
                end
                c_st_done, c_st_err: begin
                    if (load_req) begin
                        r_state     <= c_st_hdr;
                        r_byte_cnt  <= 2'd0;
                        r_index     <= '0;
                        r_csum      <= 32'd0;
                        tb_addr     <= BASE_ADDR;
                        cpu_reset_n <= 1'b0;
                        done        <= 1'b0;
                        err         <= 1'b0;
                    end
                end
                default: r_state <= c_st_hdr;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Scoreboard bench for imem_boot_loader write stream and status.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        load_req;
    logic [31:0] tb_addr;
    logic [31:0] tb_inst;
    logic        tb_we;
    logic        cpu_reset_n;
    logic        done;
    logic        err;

    int n_compared;
    int n_mismatched;
    int n_writes;
    logic [63:0] exp_q[$];

    imem_boot_loader #(
        .IMEM_WORDS (256),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .load_req    (load_req),
        .tb_addr     (tb_addr),
        .tb_inst     (tb_inst),
        .tb_we       (tb_we),
        .cpu_reset_n (cpu_reset_n),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe pops one expected {addr, inst} pair
    always @(negedge clk) begin
        if (tb_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write_addr", tb_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_eq("write_addr", tb_addr, e[63:32]);
                check_eq("write_inst", tb_inst, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                check_eq("byte_accept_timeout", 32'(t), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || err)) begin
            @(negedge clk);
            t++;
            if (t > 20) begin
                check_eq("result_timeout", 32'(t), 32'd0);
                return;
            end
        end
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check_eq("reload_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
        check_eq("reload_addr", tb_addr, 32'h0);
        check_eq("reload_done", {31'd0, done}, 32'd0);
        check_eq("reload_err", {31'd0, err}, 32'd0);
    endtask

    task automatic frame_n2(input logic [31:0] csum, input bit gaps);
        exp_q.push_back({32'h0, 32'h0050_0093});
        exp_q.push_back({32'h4, 32'h00A0_0113});
        send_word(32'd2, gaps);
        send_word(32'h0050_0093, gaps);
        send_word(32'h00A0_0113, gaps);
        send_word(csum, gaps);
        wait_end();
        @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check_eq({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e});
        check_eq({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, c});
        check_eq({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_addr"}, tb_addr, 32'h0);
        check_eq({tag, "_inst"}, tb_inst, 32'h0);
        check_eq({tag, "_we"}, {31'd0, tb_we}, 32'd0);
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_status"}, {29'd0, cpu_reset_n, done, err}, 32'd0);
    endtask

    initial begin
        int w0;
        n_compared   = 0;
        n_mismatched = 0;
        n_writes     = 0;
        reset_n  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("hdr_in_ready", {31'd0, in_ready}, 32'd1);

        // Nominal two-word frame
        frame_n2(32'h00F0_0180, 1'b0);
        check_status("frame_ok", 1'b1, 1'b0, 1'b1);

        // Same frame with random valid gaps
        pulse_load_req();
        frame_n2(32'h00F0_0180, 1'b1);
        check_status("frame_gaps", 1'b1, 1'b0, 1'b1);

        // Corrupted checksum
        pulse_load_req();
        frame_n2(32'h00F0_0181, 1'b0);
        check_status("bad_csum", 1'b0, 1'b1, 1'b0);

        // Oversize header: error right after 4th byte, no writes
        pulse_load_req();
        w0 = n_writes;
        send_word(32'd257, 1'b0);
        check_eq("oversize_err", {31'd0, err}, 32'd1);
        check_eq("oversize_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("oversize_writes", 32'(n_writes - w0), 32'd0);
        check_status("oversize", 1'b0, 1'b1, 1'b0);

        // Empty frame
        pulse_load_req();
        w0 = n_writes;
        send_word(32'd0, 1'b0);
        send_word(32'd0, 1'b0);
        wait_end();
        check_eq("empty_writes", 32'(n_writes - w0), 32'd0);
        check_status("empty", 1'b1, 1'b0, 1'b1);

        // load_req in a loading state is ignored
        pulse_load_req();
        send_byte(8'h01, 1'b0);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_end();
        @(negedge clk);
        check_status("single", 1'b1, 1'b0, 1'b1);

        // Async reset in the middle of the second word
        pulse_load_req();
        exp_q.push_back({32'h0, 32'h0050_0093});
        send_word(32'd2, 1'b0);
        send_word(32'h0050_0093, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h01, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midreset");
        check_eq("midreset_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        frame_n2(32'h00F0_0180, 1'b1);
        check_status("after_reset", 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits directly upstream of the instruction-fetch stage and produces the instruction-memory write stream (tb_addr/tb_inst plus write strobe) that the fetch stage's memory consumes.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, writes them to consecutive instruction addresses and verifies an XOR checksum.
- Holds the CPU core in reset until a load completes successfully, then releases it.

Parameters:
- IMEM_WORDS, 256, instruction-memory capacity in words; the maximum legal word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- load_req  in  1  single-cycle request to reload; honoured only in DONE or ERR.
- tb_addr  out  32  instruction write byte address.
- tb_inst  out  32  instruction write data.
- tb_we  out  1  single-cycle write strobe for tb_addr/tb_inst.
- cpu_reset_n  out  1  active-low reset to the pipeline core.
- done  out  1  load succeeded.
- err  out  1  load failed (count overflow or checksum mismatch).

Behaviour:
- Reset (async, reset_n=0): state=HDR, byte counter=0, word index=0, checksum accumulator=0, tb_addr=BASE_ADDR, tb_inst=0, tb_we=0, cpu_reset_n=0, done=0, err=0. in_ready=0 while reset_n=0.
- All outputs except in_ready are registered. in_ready is decoded from state and is 1 only in HDR, DATA and CSUM.
- Frame format: 4-byte little-endian word count N, then N little-endian words, then a 4-byte little-endian checksum equal to the XOR of all N words.
- Byte assembly: a 2-bit byte counter places byte k into bits [8k+7:8k]; the counter wraps 3->0 on the 4th byte.
- HDR: on the 4th header byte, latch N.
  - N > IMEM_WORDS -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: on the 4th byte of a word -> WRITE.
- WRITE (1 cycle, in_ready=0):
  - tb_we=1 for exactly this cycle; tb_addr=BASE_ADDR+4*index; tb_inst=assembled word.
  - The word is XORed into the accumulator and index increments.
  - If the new index == N -> CSUM, else -> DATA.
- Write latency: tb_we rises on the clock edge after the 4th byte is accepted. tb_addr and tb_inst hold their last values after tb_we deasserts.
- CSUM: on the 4th byte, compare with the accumulator: equal -> DONE, else -> ERR.
- DONE: cpu_reset_n=1 and done=1, both registered, asserted on the edge that enters DONE.
- ERR: err=1, cpu_reset_n stays 0.
- load_req in DONE or ERR -> HDR.
  - On that edge: cpu_reset_n=0, done=0, err=0; counters and accumulator clear; tb_addr returns to BASE_ADDR.
  - load_req in any other state is ignored.
- in_valid without in_ready: byte not consumed; the source must hold it.
- Gaps in in_valid mid-word or mid-header stall assembly with no timeout; partial-word state is retained.
- Reset mid-load aborts immediately. Words already written stay in memory but are not re-verified; the core stays in reset until a new complete load.
- Index width: clog2(IMEM_WORDS)+1 bits so that index == IMEM_WORDS is representable.

Test Plan:
- Reset, then frame N=2, words 0x00500093 and 0x00A00113, checksum 0x00F00180 -> two tb_we pulses at tb_addr 0x0 and 0x4 carrying those words; done=1, cpu_reset_n=1, err=0.
- Same frame with checksum byte 0 corrupted to 0x81 -> both words written; err=1, done=0, cpu_reset_n stays 0.
- Header N=IMEM_WORDS+1 (257) -> ERR right after the 4th header byte; no tb_we pulse; in_ready=0 afterwards.
- Header N=0, checksum 0x00000000 -> DONE with no tb_we pulse; cpu_reset_n=1.
- Random in_valid gaps, including mid-word, on the N=2 frame -> identical writes and result as the gap-free run; no byte dropped or duplicated.
- In DONE, pulse load_req -> cpu_reset_n=0 the next cycle and tb_addr=0x0. Reload N=1 word 0xDEADBEEF with checksum 0xDEADBEEF -> single write at 0x0; done again. Separately, assert reset_n=0 during the second word -> all outputs at reset values immediately.
